order_ingress_arbiter: RTL and testbench
========================================

# order_ingress_arbiter

Buffers orders from two producers, the UDP order parser ("net") and the on-chip strategy ("bot"). Each producer has its own FIFO. The block drops malformed orders, arbitrates between the two queues round-robin, and issues one order at a time to `matching_engine` using the engine's `input_valid`/`engine_busy` protocol. It sits directly upstream of `matching_engine` and guarantees that no order is presented while the engine is processing another.

## Interface
- `DEPTH`, 8: entries per source FIFO; power of two, ≥2.
- `ADDR_W`, 3: log2(`DEPTH`).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `net_valid`  in  1  net order present.
- `net_is_buy`  in  1  side of net order (1 = buy).
- `net_data`  in  32  {price[31:16], is_bot[15], qty[14:0]}; the incoming bit 15 is ignored.
- `net_ready`  out  1  net FIFO can accept.
- `bot_valid`, `bot_is_buy`, `bot_data`, `bot_ready`  same as the net ports, for the strategy source.
- `engine_busy`  in  1  from `matching_engine`.
- `input_valid`  out  1  single-cycle order strobe to the engine.
- `input_is_buy`  out  1  side of the issued order.
- `input_data`  out  32  issued order word.
- `drop_count`  out  16  saturating count of dropped orders.

## Operation
- Push rule: a source push occurs when `x_valid && x_ready`.
  - `x_ready = !full_x`.
  - `full_x` is the registered count == `DEPTH`; a same-cycle pop does not raise `x_ready`.
- Drop rule: an order with qty == 0 or price == 0 is accepted but not enqueued, and `drop_count` increments.
  - `drop_count` saturates at 0xFFFF.
  - If both sources drop in the same cycle, `drop_count` increments by 2, still saturating.
- Enqueue format: {`is_buy`, price, `is_bot`, qty}.
  - `is_bot` is forced to 0 for net orders and 1 for bot orders.
- Each FIFO is circular with `ADDR_W`-bit pointers that wrap modulo `DEPTH`.
  - A count register of `ADDR_W`+1 bits provides full/empty.
  - A simultaneous push and pop on the same FIFO leaves the count unchanged.
- The FSM has three states: `IDLE`, `ISSUE`, `WAIT`.
- `IDLE`: if `!engine_busy` and at least one FIFO is non-empty, grant one source.
  - Pop the granted FIFO.
  - Register `input_valid`=1, `input_is_buy`, and `input_data` from the FIFO head.
  - Record the grant in `last_grant`, then go to `ISSUE`.
- Arbitration: if only one FIFO is non-empty, that source is granted. If both are non-empty, the source ≠ `last_grant` is granted.
- `ISSUE`: `input_valid` is cleared to 0 and the state goes to `WAIT`. `input_data` and `input_is_buy` hold their values.
- `WAIT`: stays in `WAIT` while `engine_busy`=1. The state returns to `IDLE` at the first clock edge where `engine_busy`=0 is sampled.
- Reset mid-operation: all state is cleared asynchronously, FIFO contents are discarded, and no strobe is issued.

## Timing
- Reset values:
  - `input_valid`=0, `input_is_buy`=0, `input_data`=0.
  - `drop_count`=0, `net_ready`=1, `bot_ready`=1.
  - State `IDLE`, both FIFOs empty, `last_grant`=bot, so net wins the first tie.
- Latency from a push at edge E0 to an idle engine:
  - FIFO is non-empty after E0.
  - At E1 the FSM pops and asserts `input_valid`.
  - The engine latches at E2; `input_valid` falls at E2.
- `input_valid` is exactly one cycle wide.
- The engine raises `engine_busy` at E2. `WAIT` samples it from E3 onward, so no back-to-back strobe is possible.
- After `engine_busy` falls, the next issue happens 2 edges later: `WAIT`→`IDLE`, then `IDLE`→`ISSUE`.
- Maximum issue rate is one order per (engine occupancy + 3) cycles.
- A push and an issue from the same FIFO in the same cycle are both honoured.
- An order pushed into an empty FIFO is issuable from the next edge. There is no bypass path.

## Test plan
- Single net order: `net_data`=0x0064_000A (price 100, qty 10), buy, engine idle.
  - `input_valid` pulses 1 cycle, 2 edges after the push.
  - `input_data`=0x0064_000A, `input_is_buy`=1.
- Bot order: `bot_data`=0x0032_0005.
  - Issued `input_data`=0x0032_8005 (bit 15 forced to 1).
- Tie arbitration: 3 net and 3 bot orders are preloaded while `engine_busy`=1; busy is then released for 4 cycles per order.
  - Issue order is net, bot, net, bot, net, bot.
  - No `input_valid` is asserted while `engine_busy`=1.
- Full FIFO: 9 net pushes with the engine held busy.
  - `net_ready`=0 after the 8th push; the 9th push is not taken.
  - On release, exactly 8 orders are issued, in FIFO order.
- Drops: qty=0 on net and price=0 on bot in the same cycle.
  - `drop_count`=2, both readies stay 1, no issue.
  - Preloading `drop_count`=0xFFFE and then 3 further drops leaves `drop_count`=0xFFFF.
- Reset mid-`WAIT` with 4 orders queued: `rst_n` asserted low.
  - All outputs return to reset values and the FIFOs read empty.
  - After `rst_n` is released, no `input_valid` is asserted.

Source files
------------

// File: rtl/order_ingress_arbiter.sv
// Two-source order ingress: per-source FIFOs, malformed-order drop, round-robin
// arbitration and one-at-a-time issue to the matching engine.

module oia_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module order_ingress_arbiter #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        net_valid,
  input  logic        net_is_buy,
  input  logic [31:0] net_data,
  output logic        net_ready,
  input  logic        bot_valid,
  input  logic        bot_is_buy,
  input  logic [31:0] bot_data,
  output logic        bot_ready,
  input  logic        engine_busy,
  output logic        input_valid,
  output logic        input_is_buy,
  output logic [31:0] input_data,
  output logic [15:0] drop_count
);
  typedef struct packed {
    logic        is_buy;
    logic [15:0] price;
    logic        is_bot;
    logic [14:0] qty;
  } order_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int NET = 0;
  localparam int BOT = 1;

  order_t [1:0] src_ord, head;
  logic   [1:0] src_valid, accept, bad, drop, push, pop, full, empty;
  logic         unused_bit15;

  state_t state, state_nxt;
  logic   last_grant;  // 1 = bot
  logic   issue, grant_bot;

  assign unused_bit15 = ^{net_data[15], bot_data[15]};

  // Incoming bit 15 is replaced by the source identity.
  assign src_ord[NET] = {net_is_buy, net_data[31:16], 1'b0, net_data[14:0]};
  assign src_ord[BOT] = {bot_is_buy, bot_data[31:16], 1'b1, bot_data[14:0]};
  assign src_valid    = {bot_valid, net_valid};
  assign net_ready    = ~full[NET];
  assign bot_ready    = ~full[BOT];

  for (genvar i = 0; i < 2; i++) begin : g_src
    assign accept[i] = src_valid[i] & ~full[i];
    assign bad[i]    = (src_ord[i].qty == '0) || (src_ord[i].price == '0);
    assign drop[i]   = accept[i] & bad[i];
    assign push[i]   = accept[i] & ~bad[i];

    oia_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W($bits(order_t))) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (src_ord[i]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'(drop[NET]) + 17'(drop[BOT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                 drop_count <= drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!engine_busy && !(&empty)) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (!engine_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tie goes to whichever source was not granted last.
  always_comb begin
    issue     = (state == IDLE) && !engine_busy && !(&empty);
    grant_bot = (!empty[NET] && !empty[BOT]) ? ~last_grant : empty[NET];
    pop       = '0;
    pop[NET]  = issue & ~grant_bot;
    pop[BOT]  = issue &  grant_bot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_valid  <= 1'b0;
      input_is_buy <= 1'b0;
      input_data   <= '0;
      last_grant   <= 1'b1;
    end else begin
      input_valid <= issue;
      if (issue) begin
        input_is_buy <= head[grant_bot].is_buy;
        input_data   <= {head[grant_bot].price, head[grant_bot].is_bot, head[grant_bot].qty};
        last_grant   <= grant_bot;
      end
    end
  end
endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Directed bench for order_ingress_arbiter: latency, arbitration, full, drops, reset.

module tb_order_ingress_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        net_valid, net_is_buy, net_ready;
  logic [31:0] net_data;
  logic        bot_valid, bot_is_buy, bot_ready;
  logic [31:0] bot_data;
  logic        engine_busy;
  logic        input_valid, input_is_buy;
  logic [31:0] input_data;
  logic [15:0] drop_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  order_ingress_arbiter #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .net_valid    (net_valid),
    .net_is_buy   (net_is_buy),
    .net_data     (net_data),
    .net_ready    (net_ready),
    .bot_valid    (bot_valid),
    .bot_is_buy   (bot_is_buy),
    .bot_data     (bot_data),
    .bot_ready    (bot_ready),
    .engine_busy  (engine_busy),
    .input_valid  (input_valid),
    .input_is_buy (input_is_buy),
    .input_data   (input_data),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, input_valid, 0);
    check({tag, "_is_buy"}, input_is_buy, 0);
    check({tag, "_data"}, input_data, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_net_ready"}, net_ready, 1);
    check({tag, "_bot_ready"}, bot_ready, 1);
  endtask

  // Engine stand-in: busy for 4 cycles after each strobe; every strobe is
  // checked against the expected queue and against busy at its edge.
  task automatic run_engine(input int n, input string tag);
    int   got = 0;
    int   bcnt = 0;
    logic busy_at_edge;
    engine_busy = 1'b0;
    for (int c = 0; c < n*10 + 10; c++) begin
      busy_at_edge = engine_busy;
      step();
      if (input_valid) begin
        check({tag, "_strobe_while_busy"}, busy_at_edge, 0);
        if (exp_q.size() > 0) check({tag, "_order"}, {input_is_buy, input_data}, exp_q.pop_front());
        got++;
        engine_busy = 1'b1;
        bcnt = 4;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) engine_busy = 1'b0;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    rst_n = 1'b0; engine_busy = 1'b0;
    net_valid = 0; net_is_buy = 0; net_data = '0;
    bot_valid = 0; bot_is_buy = 0; bot_data = '0;
    repeat (2) step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Single net order: strobe one cycle, two edges after the push.
    net_valid = 1; net_is_buy = 1; net_data = 32'h0064_000A;
    step();
    net_valid = 0;
    check("net_no_bypass", input_valid, 0);
    step();
    check("net_valid", input_valid, 1);
    check("net_data", input_data, 32'h0064_000A);
    check("net_is_buy", input_is_buy, 1);
    step();
    check("net_valid_fall", input_valid, 0);
    check("net_data_hold", input_data, 32'h0064_000A);
    repeat (3) step();

    // Bot order gets bit 15 set.
    bot_valid = 1; bot_is_buy = 0; bot_data = 32'h0032_0005;
    step();
    bot_valid = 0;
    step();
    check("bot_valid", input_valid, 1);
    check("bot_data", input_data, 32'h0032_8005);
    check("bot_is_buy", input_is_buy, 0);
    step();
    check("bot_valid_fall", input_valid, 0);
    repeat (3) step();

    // Tie arbitration: preload 3+3 under busy, expect strict alternation from net.
    engine_busy = 1;
    for (int i = 0; i < 3; i++) begin
      net_valid = 1; net_is_buy = 1; net_data = {16'(i + 1), 16'h0001};
      bot_valid = 1; bot_is_buy = 0; bot_data = {16'(16'h10 + i), 16'h0002};
      step();
      check("tie_preload_quiet", input_valid, 0);
    end
    net_valid = 0; bot_valid = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 16'(i + 1), 1'b0, 15'd1});
      exp_q.push_back({1'b0, 16'(16'h10 + i), 1'b1, 15'd2});
    end
    repeat (2) step();
    check("tie_busy_hold", input_valid, 0);
    run_engine(6, "tie");

    // Full FIFO: 9 pushes under busy, only 8 taken.
    engine_busy = 1;
    net_valid = 1;
    for (int i = 0; i < 9; i++) begin
      net_data = {16'(16'h100 + i), 16'd3};
      net_is_buy = i[0];
      if (i < 8) exp_q.push_back({i[0], 16'(16'h100 + i), 1'b0, 15'd3});
      step();
      if (i == 7) check("full_ready_low", net_ready, 0);
    end
    net_valid = 0;
    check("full_ready_stays_low", net_ready, 0);
    check("full_bot_ready", bot_ready, 1);
    run_engine(8, "full");
    check("full_ready_back", net_ready, 1);

    // Dual drop in one cycle.
    net_valid = 1; net_data = 32'h0064_0000;
    bot_valid = 1; bot_data = 32'h0000_0005;
    step();
    net_valid = 0; bot_valid = 0;
    check("drop_two", drop_count, 16'd2);
    check("drop_net_ready", net_ready, 1);
    check("drop_bot_ready", bot_ready, 1);
    run_engine(0, "drop");

    // Saturation: walk up to 0xFFFE, then three more drops.
    net_valid = 1; bot_valid = 1;
    repeat (32766) step();
    net_valid = 0; bot_valid = 0;
    check("drop_fffe", drop_count, 16'hFFFE);
    net_valid = 1; bot_valid = 1;
    step();
    check("drop_sat_pair", drop_count, 16'hFFFF);
    bot_valid = 0;
    step();
    net_valid = 0;
    check("drop_sat_hold", drop_count, 16'hFFFF);
    run_engine(0, "sat");

    // Reset while waiting on the engine with four orders queued.
    net_valid = 1; net_is_buy = 1; net_data = 32'h0007_0007;
    step();
    net_valid = 0;
    step();
    check("rst_pre_strobe", input_valid, 1);
    engine_busy = 1;
    repeat (2) step();
    net_valid = 1; net_data = 32'h0008_0001;
    bot_valid = 1; bot_is_buy = 1; bot_data = 32'h0009_0001;
    repeat (2) step();
    net_valid = 0; bot_valid = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midwait_reset");
    step();
    rst_n = 1'b1;
    run_engine(0, "post_reset");
    check("post_reset_net_ready", net_ready, 1);
    check("post_reset_bot_ready", bot_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
